// File: rtl/spi_mon_pkg.sv
// Shared definitions for the SPI transaction monitor: FSM encoding and
// record flag layout.
package spi_mon_pkg;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Record flag bit positions
  localparam int FLAG_CRC = 0;
  localparam int FLAG_TMO = 1;
  localparam int FLAG_WR  = 2;
  localparam int FLAG_ABT = 3;
  localparam int FLAG_W   = 4;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/spi_txn_monitor_if.sv
// Bus bundle between the SPI transaction monitor and its environment.
// The master side drives the snooped SPI activity and pops records;
// the slave side is the monitor itself.
interface spi_txn_monitor_if
  import spi_mon_pkg::*;
#(
  parameter int CMD_W  = 8,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              we;
  logic              re;
  logic              spi_start;
  logic [CMD_W-1:0]  spi_cmd;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_data;
  logic [DATA_W-1:0] spi_resp;
  logic              spi_done;
  logic              crc_ok;
  logic              rec_pop;
  logic              rec_valid;
  logic [CMD_W-1:0]  rec_cmd;
  logic [ADDR_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_payload;
  flags_t            rec_flags;
  logic              busy;
  logic [CNT_W-1:0]  txn_count;
  logic [CNT_W-1:0]  err_count;
  logic              overflow;

  modport master (
    output we, re, spi_start, spi_cmd, spi_addr, spi_data, spi_resp,
           spi_done, crc_ok, rec_pop,
    input  rec_valid, rec_cmd, rec_addr, rec_payload, rec_flags, busy,
           txn_count, err_count, overflow
  );

  modport slave (
    input  we, re, spi_start, spi_cmd, spi_addr, spi_data, spi_resp,
           spi_done, crc_ok, rec_pop,
    output rec_valid, rec_cmd, rec_addr, rec_payload, rec_flags, busy,
           txn_count, err_count, overflow
  );

endinterface

// File: rtl/spi_rec_fifo.sv
// Synchronous show-ahead FIFO for monitor records. The head entry is
// visible whenever valid is high and reads as zero when empty. A push
// into a full FIFO is dropped unless a pop happens in the same cycle.
module spi_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset since head is gated by valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_txn_monitor.sv
// SPI transaction monitor: captures each start/done transaction into a
// record (command, address, payload, flags), queues records in a FIFO and
// keeps saturating transaction/error statistics.
module spi_txn_monitor
  import spi_mon_pkg::*;
#(
  parameter int CMD_W       = 8,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  spi_txn_monitor_if.slave  bus
);
  localparam int REC_W = FLAG_W + DATA_W + ADDR_W + CMD_W;
  localparam int TW    = $clog2(TIMEOUT_CYC);
  // The record is formed on the edge where the counter would reach TIMEOUT_CYC-1
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

  logic [0:0]        state;
  logic [TW-1:0]     tcnt;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;

  logic              rec_form;
  flags_t            new_flags;
  logic [DATA_W-1:0] new_payload;
  logic              rec_err;
  logic              idle_done;
  logic              drop;
  logic [REC_W-1:0]  head;
  logic              unused_re;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // re adds nothing: a start with we set is a write regardless of re
  assign unused_re = bus.re;

  assign bus.busy = (state == ST_BUSY);
  assign rec_err  = new_flags[FLAG_CRC] | new_flags[FLAG_TMO] | new_flags[FLAG_ABT];
  assign idle_done = (state == ST_IDLE) & bus.spi_done;

  // Record formation: a new start aborts, then done completes, then timeout
  always_comb begin
    rec_form    = 1'b0;
    new_flags   = '0;
    new_payload = '0;
    if (state == ST_BUSY) begin
      if (bus.spi_start) begin
        rec_form            = 1'b1;
        new_flags[FLAG_ABT] = 1'b1;
        new_flags[FLAG_WR]  = wr_q;
        new_payload         = wr_q ? data_q : '0;
      end else if (bus.spi_done) begin
        rec_form            = 1'b1;
        new_flags[FLAG_WR]  = wr_q;
        new_flags[FLAG_CRC] = ~bus.crc_ok;
        new_payload         = wr_q ? data_q : bus.spi_resp;
      end else if (tcnt == TMO_LAST) begin
        rec_form            = 1'b1;
        new_flags[FLAG_TMO] = 1'b1;
        new_flags[FLAG_WR]  = wr_q;
      end
    end
  end

  // FSM and timeout counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.spi_start) begin
        state <= ST_BUSY;
        tcnt  <= '0;
      end
    end else begin
      if (bus.spi_start)     tcnt  <= '0;
      else if (rec_form)     state <= ST_IDLE;
      else                   tcnt  <= tcnt + TW'(1);
    end
  end

  // Capture of the transaction fields on every start
  always_ff @(posedge clk) begin
    if (bus.spi_start) begin
      cmd_q  <= bus.spi_cmd;
      addr_q <= bus.spi_addr;
      data_q <= bus.spi_data;
      wr_q   <= bus.we;
    end
  end

  // Statistics and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.txn_count <= '0;
      bus.err_count <= '0;
      bus.overflow  <= 1'b0;
    end else begin
      if (rec_form) bus.txn_count <= sat_inc(bus.txn_count);
      if ((rec_form & rec_err) | idle_done) bus.err_count <= sat_inc(bus.err_count);
      if (drop) bus.overflow <= 1'b1;
    end
  end

  spi_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rec_form),
    .push_data ({new_flags, new_payload, addr_q, cmd_q}),
    .pop       (bus.rec_pop),
    .valid     (bus.rec_valid),
    .head      (head),
    .drop      (drop)
  );

  assign {bus.rec_flags, bus.rec_payload, bus.rec_addr, bus.rec_cmd} = head;

endmodule

// File: tb/tb_spi_txn_monitor.sv
// Directed testbench for spi_txn_monitor. A main instance (default
// timeout) covers capture, errors, abort, FIFO overflow and reset; a
// second instance with TIMEOUT_CYC=16 covers the timeout path.
module tb_spi_txn_monitor;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  spi_txn_monitor_if #(.CMD_W(8), .ADDR_W(24), .DATA_W(32), .CNT_W(16)) bus ();
  spi_txn_monitor_if #(.CMD_W(8), .ADDR_W(24), .DATA_W(32), .CNT_W(16)) bus_t ();

  spi_txn_monitor #(
    .CMD_W(8), .ADDR_W(24), .DATA_W(32), .DEPTH(8), .TIMEOUT_CYC(1024), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_txn_monitor #(
    .CMD_W(8), .ADDR_W(24), .DATA_W(32), .DEPTH(8), .TIMEOUT_CYC(16), .CNT_W(16)
  ) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [31:0] data, input logic w, input logic r);
    bus.spi_start = 1'b1;
    bus.spi_cmd   = cmd;
    bus.spi_addr  = addr;
    bus.spi_data  = data;
    bus.we        = w;
    bus.re        = r;
    tick();
    bus.spi_start = 1'b0;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
  endtask

  task automatic done_txn(input logic [31:0] resp, input logic ok);
    bus.spi_done = 1'b1;
    bus.spi_resp = resp;
    bus.crc_ok   = ok;
    tick();
    bus.spi_done = 1'b0;
    bus.crc_ok   = 1'b0;
  endtask

  task automatic pop_rec();
    bus.rec_pop = 1'b1;
    tick();
    bus.rec_pop = 1'b0;
  endtask

  logic [7:0] exp_cmd [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};

  initial begin
    {bus.we, bus.re, bus.spi_start, bus.spi_done, bus.crc_ok, bus.rec_pop} = '0;
    bus.spi_cmd = '0; bus.spi_addr = '0; bus.spi_data = '0; bus.spi_resp = '0;
    {bus_t.we, bus_t.re, bus_t.spi_start, bus_t.spi_done, bus_t.crc_ok, bus_t.rec_pop} = '0;
    bus_t.spi_cmd = '0; bus_t.spi_addr = '0; bus_t.spi_data = '0; bus_t.spi_resp = '0;
    rst = 1'b0;
    tick();
    tick();

    chk("rst_busy",  bus.busy, 0);
    chk("rst_valid", bus.rec_valid, 0);
    chk("rst_flags", bus.rec_flags, 0);
    chk("rst_txn",   bus.txn_count, 0);
    chk("rst_err",   bus.err_count, 0);
    chk("rst_ovf",   bus.overflow, 0);
    rst = 1'b1;
    tick();

    // Write with good CRC, done 40 cycles after start
    start_txn(8'h02, 24'h000100, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("wr_busy", bus.busy, 1);
    repeat (39) tick();
    chk("wr_wait_valid", bus.rec_valid, 0);
    done_txn(32'h0, 1'b1);
    chk("wr_busy_end", bus.busy, 0);
    chk("wr_valid",   bus.rec_valid, 1);
    chk("wr_flags",   bus.rec_flags, 4'b0100);
    chk("wr_payload", bus.rec_payload, 32'hDEADBEEF);
    chk("wr_cmd",     bus.rec_cmd, 8'h02);
    chk("wr_addr",    bus.rec_addr, 24'h000100);
    chk("wr_txn",     bus.txn_count, 1);
    chk("wr_err",     bus.err_count, 0);
    pop_rec();
    chk("pop_empty",   bus.rec_valid, 0);
    chk("pop_zero_pl", bus.rec_payload, 0);
    pop_rec();
    chk("pop_empty_ignored", bus.rec_valid, 0);

    // Read with CRC error
    start_txn(8'h03, 24'h000200, 32'h0, 1'b0, 1'b1);
    done_txn(32'h12345678, 1'b0);
    chk("rd_payload", bus.rec_payload, 32'h12345678);
    chk("rd_flags",   bus.rec_flags, 4'b0001);
    chk("rd_addr",    bus.rec_addr, 24'h000200);
    chk("rd_err",     bus.err_count, 1);
    chk("rd_txn",     bus.txn_count, 2);
    pop_rec();

    // Abort by second start; first start has we=re=1 (treated as write)
    start_txn(8'h10, 24'h000010, 32'hAAAA0001, 1'b1, 1'b1);
    tick();
    start_txn(8'h11, 24'h000020, 32'h0, 1'b0, 1'b1);
    chk("abt_busy",    bus.busy, 1);
    chk("abt_valid",   bus.rec_valid, 1);
    chk("abt_flags",   bus.rec_flags, 4'b1100);
    chk("abt_payload", bus.rec_payload, 32'hAAAA0001);
    chk("abt_cmd",     bus.rec_cmd, 8'h10);
    done_txn(32'h00000055, 1'b1);
    chk("abt_txn", bus.txn_count, 4);
    chk("abt_err", bus.err_count, 2);
    pop_rec();
    chk("abt2_cmd",     bus.rec_cmd, 8'h11);
    chk("abt2_flags",   bus.rec_flags, 4'b0000);
    chk("abt2_payload", bus.rec_payload, 32'h55);
    pop_rec();
    chk("abt_drained", bus.rec_valid, 0);

    // Done while idle: error count only
    done_txn(32'h1, 1'b1);
    chk("idle_done_err",   bus.err_count, 3);
    chk("idle_done_valid", bus.rec_valid, 0);
    chk("idle_done_txn",   bus.txn_count, 4);

    // Timeout on the TIMEOUT_CYC=16 instance
    bus_t.spi_start = 1'b1;
    bus_t.spi_cmd   = 8'h21;
    bus_t.spi_addr  = 24'h000300;
    tick();
    bus_t.spi_start = 1'b0;
    repeat (14) tick();
    chk("tmo_busy_14",  bus_t.busy, 1);
    chk("tmo_valid_14", bus_t.rec_valid, 0);
    tick();
    chk("tmo_busy_15",  bus_t.busy, 0);
    chk("tmo_valid_15", bus_t.rec_valid, 1);
    chk("tmo_flags",    bus_t.rec_flags, 4'b0010);
    chk("tmo_payload",  bus_t.rec_payload, 0);
    chk("tmo_err",      bus_t.err_count, 1);

    // Fill past depth without popping
    for (int i = 0; i < 9; i++) begin
      start_txn(8'(i), 24'(i), 32'(i + 100), 1'b1, 1'b0);
      done_txn(32'h0, 1'b1);
      if (i == 7) chk("fill8_ovf", bus.overflow, 0);
    end
    chk("fill9_ovf",  bus.overflow, 1);
    chk("fill9_txn",  bus.txn_count, 13);
    chk("fill9_head", bus.rec_cmd, 8'd0);
    // Push coinciding with pop while full: no drop
    start_txn(8'd9, 24'd9, 32'd109, 1'b1, 1'b0);
    bus.rec_pop = 1'b1;
    done_txn(32'h0, 1'b1);
    bus.rec_pop = 1'b0;
    chk("pushpop_txn", bus.txn_count, 14);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_cmd%0d", i), bus.rec_cmd, exp_cmd[i]);
      pop_rec();
    end
    chk("drain_empty", bus.rec_valid, 0);

    // Reset in the middle of a transaction
    start_txn(8'h77, 24'h000777, 32'h77777777, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_busy",  bus.busy, 0);
    chk("mrst_valid", bus.rec_valid, 0);
    chk("mrst_flags", bus.rec_flags, 0);
    chk("mrst_txn",   bus.txn_count, 0);
    chk("mrst_err",   bus.err_count, 0);
    chk("mrst_ovf",   bus.overflow, 0);
    done_txn(32'h0, 1'b1);
    chk("mrst_done_valid", bus.rec_valid, 0);
    chk("mrst_done_txn",   bus.txn_count, 0);
    chk("mrst_done_err",   bus.err_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_monitor.md
SPI_TXN_MONITOR -- requirements
Module: spi_txn_monitor

Interface
REQ-001 SHALL have parameter CMD_W, default 8, SPI command width.
REQ-002 SHALL have parameter ADDR_W, default 24, SPI address width.
REQ-003 SHALL have parameter DATA_W, default 32, data/response width.
REQ-004 SHALL have parameter DEPTH, default 8, record FIFO entries; power of two, at least 2.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, cycles from start to done before timeout; at least 2.
REQ-006 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-007 SHALL have ports as follows.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- we, re  in  1 each  write / read transaction qualifiers.
- spi_start  in  1  one-cycle transaction start pulse.
- spi_cmd  in  CMD_W  command.
- spi_addr  in  ADDR_W  address.
- spi_data  in  DATA_W  write data.
- spi_resp  in  DATA_W  read response.
- spi_done  in  1  one-cycle completion pulse.
- crc_ok  in  1  CRC result, valid with spi_done.
- rec_pop  in  1  consume head record.
- rec_valid  out  1  FIFO non-empty.
- rec_cmd  out  CMD_W  head record command.
- rec_addr  out  ADDR_W  head record address.
- rec_payload  out  DATA_W  head record payload.
- rec_flags  out  4  head record flags: [0] crc_err, [1] timeout, [2] write, [3] aborted.
- busy  out  1  transaction in flight.
- txn_count  out  CNT_W  completed records.
- err_count  out  CNT_W  records with any error flag.
- overflow  out  1  sticky; a record was dropped.

Function
REQ-010 SHALL implement FSM with states IDLE and BUSY; busy=1 exactly in BUSY.
REQ-011 In IDLE, spi_start=1 SHALL latch cmd, addr, we, and spi_data, clear the timeout counter, and go to BUSY.
REQ-012 In BUSY, spi_done=1 SHALL form a record: write = latched we; payload = latched data if write, else spi_resp sampled with done; crc_err = !crc_ok; then go to IDLE.
REQ-013 In BUSY without done, the timeout counter SHALL increment; at TIMEOUT_CYC-1 a record SHALL be formed with timeout=1, crc_err=0, payload=0, and FSM go to IDLE.
REQ-014 spi_start in BUSY, with or without done, SHALL close the current record with aborted=1 and restart capture with the new command; FSM stays BUSY.
REQ-015 spi_done in IDLE SHALL be ignored except for err_count increment; no record.
REQ-016 Records SHALL be pushed on the same edge they form; rec_valid and rec_* SHALL reflect the head record from the next cycle (show-ahead).
REQ-017 rec_pop with rec_valid=0 SHALL be ignored.
REQ-018 A push when full SHALL be dropped and set overflow, unless rec_pop is asserted in the same cycle, in which case both SHALL occur.
REQ-019 txn_count SHALL increment per formed record, including dropped ones.
REQ-020 err_count SHALL increment per record with any flag[0], [1] or [3] set.
REQ-021 Both counters SHALL saturate at all-ones.
REQ-022 rec_* SHALL be 0 when rec_valid=0.
REQ-023 we=re=1 at start SHALL be treated as write.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE and an empty FIFO, and zero busy, rec_valid, rec_* outputs, both counters, overflow, and the timeout counter.
REQ-031 Reset during BUSY SHALL discard the in-flight transaction with no record.

Structure
REQ-040 Flag bit indices and the FSM state encoding SHALL reside in shared package spi_mon_pkg.
REQ-041 Record storage SHALL be one sub-module, spi_rec_fifo, a parametrised synchronous show-ahead FIFO.

Verification
REQ-050 Write 0x02/0x000100/0xDEADBEEF, done after 40 cycles with crc_ok=1 -> one record with flags=4'b0100, payload 0xDEADBEEF, txn_count=1, err_count=0.
REQ-051 Read 0x03/0x000200, done with resp 0x12345678 and crc_ok=0 -> payload 0x12345678, flags=4'b0001, err_count=1.
REQ-052 Start with no done, TIMEOUT_CYC=16 -> record with flags[1]=1 formed exactly 15 cycles after start; busy=0 next cycle.
REQ-053 Second start while BUSY -> first record aborted=1, second record completes normally; txn_count=2.
REQ-054 With DEPTH=8, 9 transactions and no pop -> 8 records held, overflow=1, txn_count=9; push with simultaneous pop when full -> no drop.
REQ-055 rst=0 mid-transaction -> all outputs 0 next cycle; a later done produces no record.
